// File: rtl/fact_pkg.sv
// Shared types and width constants for the factorial sequencer.
package fact_pkg;

   localparam int unsigned FACT_N_W          = 6;
   localparam int unsigned FACT_RES_W        = 64;
   localparam int unsigned FACT_MAX_N_NO_OVF = 20;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      REQ  = 3'd2,
      WAIT = 3'd3,
      DONE = 3'd4
   } fact_state_e;

endpackage : fact_pkg

// File: rtl/fact_step_cnt.sv
// Loadable down-counter that saturates at zero and exposes a registered "<= 1" flag.
module fact_step_cnt
   import fact_pkg::*;
#(
   parameter int unsigned W = FACT_N_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         is_le1
);

   logic [W-1:0] cnt_nxt;

   // Load has priority over decrement.
   always_comb begin
      cnt_nxt = cnt;
      if (load) begin
         cnt_nxt = load_val;
      end else if (dec && (cnt != '0)) begin
         cnt_nxt = cnt - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt    <= '0;
         is_le1 <= 1'b1;
      end else begin
         cnt    <= cnt_nxt;
         is_le1 <= (cnt_nxt <= W'(1));
      end
   end

endmodule : fact_step_cnt

// File: rtl/fact_seq_ctrl.sv
// Factorial sequencer: drives an external multiplier from N down to 2 and accumulates N!.
// Optional multiplier watchdog with err output when FACT_SEQ_TIMEOUT_EN is defined.
module fact_seq_ctrl
   import fact_pkg::*;
#(
   parameter int unsigned N_W   = FACT_N_W,
   parameter int unsigned RES_W = FACT_RES_W
`ifdef FACT_SEQ_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 op_start,
   input  logic [N_W-1:0]       op_n,
   output logic                 busy,
   output logic                 done,
   output logic [RES_W-1:0]     result,
   output logic                 ovf,
   output logic                 mul_start,
   output logic [RES_W-1:0]     mul_a,
   output logic [N_W-1:0]       mul_b,
   input  logic                 mul_done,
   input  logic [RES_W+N_W-1:0] mul_prod
`ifdef FACT_SEQ_TIMEOUT_EN
   ,
   output logic                 err
`endif
);

   localparam int unsigned P_W = RES_W + N_W;

   fact_state_e state, state_nxt;

   logic [RES_W-1:0] acc, acc_nxt;
   logic [RES_W-1:0] result_nxt;
   logic [RES_W-1:0] mul_a_nxt;
   logic [N_W-1:0]   mul_b_nxt;
   logic             busy_nxt, done_nxt, ovf_nxt, mul_start_nxt;

   logic             cnt_load, cnt_dec, cnt_le1;
   logic [N_W-1:0]   cnt;

   fact_step_cnt #(.W(N_W)) u_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .load_val (op_n),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .is_le1   (cnt_le1)
   );

`ifdef FACT_SEQ_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

   logic             tmo_load, tmo_dec, tmo_le1, tmo_expired_c;
   logic [TMO_W-1:0] tmo_cnt;
   logic             err_nxt;

   // Watchdog is armed on every request and counts idle WAIT cycles.
   fact_step_cnt #(.W(TMO_W)) u_tmo (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (tmo_load),
      .load_val (TMO_W'(TIMEOUT_CYC)),
      .dec      (tmo_dec),
      .cnt      (tmo_cnt),
      .is_le1   (tmo_le1)
   );

   assign tmo_expired_c = tmo_le1 | (tmo_cnt == '0);
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and next-value logic for every registered output.
   always_comb begin
      state_nxt     = state;
      acc_nxt       = acc;
      result_nxt    = result;
      ovf_nxt       = ovf;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      mul_start_nxt = 1'b0;
      mul_a_nxt     = mul_a;
      mul_b_nxt     = mul_b;
      cnt_load      = 1'b0;
      cnt_dec       = 1'b0;
`ifdef FACT_SEQ_TIMEOUT_EN
      tmo_load      = 1'b0;
      tmo_dec       = 1'b0;
      err_nxt       = err;
`endif

      case (state)
         IDLE: begin
            if (op_start) begin
               cnt_load  = 1'b1;
               acc_nxt   = RES_W'(1);
               ovf_nxt   = 1'b0;
               busy_nxt  = 1'b1;
               state_nxt = LOAD;
`ifdef FACT_SEQ_TIMEOUT_EN
               err_nxt   = 1'b0;
`endif
            end
         end

         LOAD: begin
            if (cnt_le1) begin
               result_nxt = RES_W'(1);
               done_nxt   = 1'b1;
               busy_nxt   = 1'b0;
               state_nxt  = DONE;
            end else begin
               state_nxt  = REQ;
            end
         end

         REQ: begin
            mul_start_nxt = 1'b1;
            mul_a_nxt     = acc;
            mul_b_nxt     = cnt;
            state_nxt     = WAIT;
`ifdef FACT_SEQ_TIMEOUT_EN
            tmo_load      = 1'b1;
`endif
         end

         WAIT: begin
            if (mul_done) begin
               acc_nxt = mul_prod[RES_W-1:0];
               ovf_nxt = ovf | (mul_prod[P_W-1:RES_W] != '0);
               cnt_dec = 1'b1;
               // cnt is about to drop to 1: this was the last multiply.
               if (cnt == N_W'(2)) begin
                  result_nxt = mul_prod[RES_W-1:0];
                  done_nxt   = 1'b1;
                  busy_nxt   = 1'b0;
                  state_nxt  = DONE;
               end else begin
                  state_nxt  = REQ;
               end
`ifdef FACT_SEQ_TIMEOUT_EN
            end else if (tmo_expired_c) begin
               result_nxt = '0;
               err_nxt    = 1'b1;
               done_nxt   = 1'b1;
               busy_nxt   = 1'b0;
               state_nxt  = DONE;
            end else begin
               tmo_dec    = 1'b1;
`endif
            end
         end

         DONE: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc       <= '0;
         result    <= '0;
         ovf       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mul_start <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
      end else begin
         acc       <= acc_nxt;
         result    <= result_nxt;
         ovf       <= ovf_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         mul_start <= mul_start_nxt;
         mul_a     <= mul_a_nxt;
         mul_b     <= mul_b_nxt;
      end
   end

`ifdef FACT_SEQ_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         err <= 1'b0;
      end else begin
         err <= err_nxt;
      end
   end
`endif

endmodule : fact_seq_ctrl

// File: tb/tb_fact_seq_ctrl.sv
// Self-checking bench for fact_seq_ctrl with a behavioural multiplier responder and factorial model.
module tb_fact_seq_ctrl;
   import fact_pkg::*;

   localparam int unsigned N_W   = FACT_N_W;
   localparam int unsigned RES_W = FACT_RES_W;
   localparam int unsigned P_W   = N_W + RES_W;
   localparam int          BUDGET = 4000;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             op_start;
   logic [N_W-1:0]   op_n;
   logic             busy, done, ovf, mul_start;
   logic [RES_W-1:0] result, mul_a;
   logic [N_W-1:0]   mul_b;
   logic             mul_done;
   logic [P_W-1:0]   mul_prod;
`ifdef FACT_SEQ_TIMEOUT_EN
   logic             err;
`endif

   fact_seq_ctrl #(
      .N_W   (N_W),
      .RES_W (RES_W)
`ifdef FACT_SEQ_TIMEOUT_EN
      ,
      .TIMEOUT_CYC (16)
`endif
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .op_start  (op_start),
      .op_n      (op_n),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .ovf       (ovf),
      .mul_start (mul_start),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_done  (mul_done),
      .mul_prod  (mul_prod)
`ifdef FACT_SEQ_TIMEOUT_EN
      ,
      .err       (err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Responder controls (written only by the main sequence).
   bit resp_en    = 1'b1;
   int lat_fixed  = 3;
   int inject_req = 0;

   // Written only by the responder / monitors.
   logic [RES_W-1:0] rec_a[$];
   int               rec_b[$];
   int               unstable = 0;
   int               done_seen = 0;
   int               mstart_seen = 0;

   // Reference model outputs.
   logic [RES_W-1:0] exp_a[$];
   int               exp_b[$];
   logic [RES_W-1:0] exp_res;
   logic             exp_ovf;

   typedef struct {
      int               n;
      logic [RES_W-1:0] res;
      logic             ovf;
      int               nmul;
   } vec_t;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // N! as a chain of multiplies N*(N-1)*..*2, tracking bits lost above RES_W.
   function automatic void build_model(input int n);
      logic [P_W-1:0]   full;
      logic [RES_W-1:0] a;
      exp_a.delete();
      exp_b.delete();
      a       = 1;
      exp_ovf = 1'b0;
      for (int k = n; k >= 2; k--) begin
         exp_a.push_back(a);
         exp_b.push_back(k);
         full = P_W'(a) * P_W'(k);
         a    = full[RES_W-1:0];
         if (full[P_W-1:RES_W] != 0) exp_ovf = 1'b1;
      end
      exp_res = a;
   endfunction

   // Multiplier responder with configurable latency; also serves stray-pulse injections.
   initial begin
      int served = 0;
      mul_done = 1'b0;
      mul_prod = '0;
      forever begin
         @(posedge clk); #1;
         if (inject_req != served) begin
            served   = inject_req;
            mul_prod = P_W'(64'hDEAD_BEEF);
            mul_done = 1'b1;
            @(posedge clk); #1;
            mul_done = 1'b0;
         end else if (resp_en && mul_start) begin
            logic [RES_W-1:0] a;
            logic [N_W-1:0]   b;
            int               lat;
            a = mul_a;
            b = mul_b;
            rec_a.push_back(a);
            rec_b.push_back(int'(b));
            lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
            if (lat > 1) begin
               repeat (lat - 1) @(posedge clk);
               #1;
            end
            if (mul_a !== a || mul_b !== b) unstable++;
            mul_prod = P_W'(a) * P_W'(b);
            mul_done = 1'b1;
            @(posedge clk); #1;
            mul_done = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (done) done_seen++;
      if (mul_start) mstart_seen++;
   end

   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!done && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // One complete operation with protocol checks against the model.
   task automatic run_op(input int n, input string tag, output logic [RES_W-1:0] got_res,
                         output logic got_ovf, output int got_nmul);
      int cyc, base_q, base_done;
      bit pairs_ok;
      build_model(n);
      base_q    = rec_a.size();
      base_done = done_seen;
      @(negedge clk);
      op_start = 1'b1;
      op_n     = N_W'(n);
      @(negedge clk);
      op_start = 1'b0;
      check({tag, " busy_after_accept"}, busy, 1);
      wait_done(cyc);
      check({tag, " done_seen"}, done, 1);
      check({tag, " busy_low_at_done"}, busy, 0);
      check({tag, " result"}, result, exp_res);
      check({tag, " ovf"}, ovf, exp_ovf);
      if (n <= 1) check({tag, " short_latency"}, cyc, 2);
      got_res = result;
      got_ovf = ovf;
      @(negedge clk);
      check({tag, " done_one_cycle"}, done, 0);
      check({tag, " done_count"}, done_seen - base_done, 1);
      got_nmul = rec_a.size() - base_q;
      check({tag, " mul_count"}, got_nmul, exp_a.size());
      pairs_ok = (got_nmul == exp_a.size());
      for (int i = 0; pairs_ok && i < got_nmul; i++) begin
         if (rec_a[base_q + i] !== exp_a[i] || rec_b[base_q + i] != exp_b[i]) pairs_ok = 1'b0;
      end
      check({tag, " mul_pairs"}, pairs_ok, 1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " busy"}, busy, 0);
      check({tag, " done"}, done, 0);
      check({tag, " result"}, result, 0);
      check({tag, " ovf"}, ovf, 0);
      check({tag, " mul_start"}, mul_start, 0);
      check({tag, " mul_a"}, mul_a, 0);
      check({tag, " mul_b"}, mul_b, 0);
   endtask

   initial begin
      vec_t             vecs[7];
      logic [RES_W-1:0] r;
      logic             o;
      int               nm, cyc, base_q, base_done, base_ms;

      vecs[0] = '{0,  64'd1, 1'b0, 0};
      vecs[1] = '{1,  64'd1, 1'b0, 0};
      vecs[2] = '{2,  64'd2, 1'b0, 1};
      vecs[3] = '{5,  64'd120, 1'b0, 4};
      vecs[4] = '{20, 64'd2432902008176640000, 1'b0, 19};
      vecs[5] = '{21, 64'd14197454024290336768, 1'b1, 20};
      vecs[6] = '{3,  64'd6, 1'b0, 2};

      reset_n  = 1'b0;
      op_start = 1'b0;
      op_n     = '0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset_n = 1'b1;

      // Table-driven runs with a fixed 3-cycle multiplier.
      lat_fixed = 3;
      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].n, $sformatf("vec%0d", vecs[i].n), r, o, nm);
         check($sformatf("tbl%0d result", vecs[i].n), r, vecs[i].res);
         check($sformatf("tbl%0d ovf", vecs[i].n), o, vecs[i].ovf);
         check($sformatf("tbl%0d nmul", vecs[i].n), nm, vecs[i].nmul);
      end

      // Randomised operands and multiplier latency.
      lat_fixed = 0;
      for (int i = 0; i < 10; i++) begin
         run_op(int'($urandom_range(0, 25)), $sformatf("rnd%0d", i), r, o, nm);
      end

      // op_start while busy is dropped; op_start during the done cycle is dropped.
      lat_fixed = 3;
      base_q    = rec_a.size();
      @(negedge clk);
      op_start = 1'b1;
      op_n     = N_W'(6);
      @(negedge clk);
      op_start = 1'b0;
      repeat (5) @(negedge clk);
      op_start = 1'b1;
      op_n     = N_W'(3);
      @(negedge clk);
      op_start = 1'b0;
      wait_done(cyc);
      check("busy_ign done", done, 1);
      check("busy_ign result", result, 720);
      op_start = 1'b1;
      op_n     = N_W'(2);
      @(negedge clk);
      op_start = 1'b0;
      check("done_cycle_start busy", busy, 0);
      repeat (4) @(negedge clk);
      check("busy_ign mul_count", rec_a.size() - base_q, 5);
      check("done_cycle_start idle", busy, 0);
      run_op(3, "after_ign", r, o, nm);

      // Reset in the middle of a WAIT, followed by a stray mul_done.
      resp_en   = 1'b0;
      base_ms   = mstart_seen;
      @(negedge clk);
      op_start = 1'b1;
      op_n     = N_W'(7);
      @(negedge clk);
      op_start = 1'b0;
      cyc = 0;
      while (mstart_seen == base_ms && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("rst_wait reached", mstart_seen - base_ms, 1);
      @(negedge clk);
      reset_n   = 1'b0;
      base_done = done_seen;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      inject_req++;
      repeat (6) @(negedge clk);
      check_reset_vals("mid_reset");
      check("mid_reset no_done", done_seen - base_done, 0);
      check("mid_reset no_req", mstart_seen - base_ms, 1);
      resp_en = 1'b1;
      run_op(4, "post_reset", r, o, nm);

`ifdef FACT_SEQ_TIMEOUT_EN
      // Multiplier never answers: watchdog ends the run with err.
      resp_en = 1'b0;
      @(negedge clk);
      op_start = 1'b1;
      op_n     = N_W'(4);
      @(negedge clk);
      op_start = 1'b0;
      wait_done(cyc);
      check("tmo done", done, 1);
      check("tmo err", err, 1);
      check("tmo result", result, 0);
      check("tmo latency", cyc, 19);
      resp_en = 1'b1;
      repeat (4) @(negedge clk);
      run_op(4, "tmo_recover", r, o, nm);
      check("tmo_recover err", err, 0);
`endif

      check("operands_stable", unstable, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fact_seq_ctrl
